// File: rtl/div_issue.sv
// div_issue: issues one DIV/DIVU/REM/REMU op at a time to an external multi-cycle
// divider and returns the selected result. Optional watchdog abort: DIV_ISSUE_TIMEOUT_EN.
module div_issue #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_rs1_i,
    input  logic [WIDTH-1:0] req_rs2_i,
    input  logic [3:0]       req_tag_i,
    output logic             div_rst_o,
    output logic             div_valid_o,
    output logic             div_unsigned_o,
    output logic             div_out_type_o,
    output logic [WIDTH-1:0] div_n_o,
    output logic [WIDTH-1:0] div_d_o,
    input  logic             div_ready_i,
    input  logic [WIDTH-1:0] div_q_i,
    input  logic [WIDTH-1:0] div_r_i,
    input  logic [1:0]       div_error_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic [3:0]       rsp_tag_o,
    output logic [1:0]       rsp_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] rs1_q;
    logic [WIDTH-1:0] rs2_q;
    logic [3:0]       tag_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       err_q;
    logic             abort;

`ifdef DIV_ISSUE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wd_cnt <= '0;
        end else if (state == LOAD) begin
            wd_cnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // A divider result arriving on the expiry cycle takes priority over the abort.
    assign abort = (state == WAIT) && !div_ready_i && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid_i) state_next = LOAD;
            LOAD:    state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_ready_i || abort) state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            op_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            tag_q  <= '0;
            data_q <= '0;
            err_q  <= '0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                op_q  <= req_op_i;
                rs1_q <= req_rs1_i;
                rs2_q <= req_rs2_i;
                tag_q <= req_tag_i;
            end
            if (state == WAIT) begin
                if (div_ready_i) begin
                    data_q <= op_q[1] ? div_r_i : div_q_i;
                    if (rs2_q == '0) begin
                        err_q <= 2'b01;
                    end else if (div_error_i != '0) begin
                        err_q <= 2'b11;
                    end else begin
                        err_q <= 2'b00;
                    end
                end else if (abort) begin
                    data_q <= '1;
                    err_q  <= 2'b10;
                end
            end
        end
    end

    // Handshake outputs are gated by rst_i so they fall in the reset cycle itself.
    assign req_ready_o    = rst_i && (state == IDLE);
    assign div_valid_o    = rst_i && (state == ISSUE);
    assign rsp_valid_o    = rst_i && (state == RESP);
    assign div_rst_o      = !rst_i || (state == LOAD) || abort;
    assign div_unsigned_o = op_q[0];
    assign div_out_type_o = ~op_q[1];
    assign div_n_o        = rs1_q;
    assign div_d_o        = rs2_q;
    assign rsp_data_o     = data_q;
    assign rsp_tag_o      = tag_q;
    assign rsp_err_o      = err_q;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: randomized ops against a transaction-level timing/result
// model plus a behavioural divider; also builds with DIV_ISSUE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_div_issue;

    localparam int unsigned W = 32;
`ifdef DIV_ISSUE_TIMEOUT_EN
    localparam int unsigned TO    = 8;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 64;
    localparam bit          TO_EN = 1'b0;
`endif
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [1:0]   req_op_i = '0;
    logic [W-1:0] req_rs1_i = '0;
    logic [W-1:0] req_rs2_i = '0;
    logic [3:0]   req_tag_i = '0;
    logic         div_rst_o;
    logic         div_valid_o;
    logic         div_unsigned_o;
    logic         div_out_type_o;
    logic [W-1:0] div_n_o;
    logic [W-1:0] div_d_o;
    logic         div_ready_i = 1'b0;
    logic [W-1:0] div_q_i = '0;
    logic [W-1:0] div_r_i = '0;
    logic [1:0]   div_error_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [W-1:0] rsp_data_o;
    logic [3:0]   rsp_tag_o;
    logic [1:0]   rsp_err_o;

    always #5 clk = ~clk;

    div_issue #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
        .div_rst_o(div_rst_o), .div_valid_o(div_valid_o), .div_unsigned_o(div_unsigned_o),
        .div_out_type_o(div_out_type_o), .div_n_o(div_n_o), .div_d_o(div_d_o),
        .div_ready_i(div_ready_i), .div_q_i(div_q_i), .div_r_i(div_r_i), .div_error_i(div_error_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          cyc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // RISC-V style divide: /0 gives all-ones quotient, overflow gives INT_MIN, rem 0.
    function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic uns,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (d == '0) begin
            q = '1;
            r = n;
        end else if (uns) begin
            q = n / d;
            r = n % d;
        end else if (n == {1'b1, {(W-1){1'b0}}} && d == '1) begin
            q = n;
            r = '0;
        end else begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end
    endfunction

    // Stimulus-controlled divider behaviour for the op in flight.
    int unsigned cur_lat = 0;
    logic [1:0]  cur_err = '0;

    // Behavioural divider: latches n/d under reset, answers cur_lat edges after start.
    logic [W-1:0] dv_n, dv_d, dq, dr;
    logic         dv_uns;
    int unsigned  dv_cnt = 0;

    always @(posedge clk) begin
        if (div_rst_o) begin
            div_ready_i <= 1'b0;
            dv_cnt      <= 0;
            dv_n        <= div_n_o;
            dv_d        <= div_d_o;
            dv_uns      <= div_unsigned_o;
            div_q_i     <= $urandom;
            div_r_i     <= $urandom;
            div_error_i <= 2'($urandom);
        end else if (div_valid_o) begin
            check("stale_result", div_ready_i, 1'b0);
            if (cur_lat == 0) begin
                ref_div(dv_n, dv_d, dv_uns, dq, dr);
                div_q_i <= dq; div_r_i <= dr; div_error_i <= cur_err; div_ready_i <= 1'b1;
            end else begin
                dv_cnt <= cur_lat;
            end
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                ref_div(dv_n, dv_d, dv_uns, dq, dr);
                div_q_i <= dq; div_r_i <= dr; div_error_i <= cur_err; div_ready_i <= 1'b1;
            end
        end
    end

    // Transaction model: one op at a time, fixed offsets from its LOAD cycle (m_acc).
    bit           m_busy = 1'b0;
    bit           m_to = 1'b0;
    bit           m_rsp_now = 1'b0;
    bit           hs;
    int           m_acc = 0;
    longint       m_rsp_rel = 0;
    logic [1:0]   m_op = '0;
    logic [W-1:0] m_rs1 = '0, m_rs2 = '0, m_data = '0, mq, mr;
    logic [3:0]   m_tag = '0;
    logic [1:0]   m_err = '0;
    longint       prel;

    always @(posedge clk) begin
        prel = longint'(cyc) - longint'(m_acc);
        hs = rst_i && m_busy && prel >= m_rsp_rel && rsp_ready_i;
        cyc++;
        if (!rst_i || hs) begin
            m_busy = 1'b0;
        end else if (!m_busy && req_valid_i) begin
            m_busy    = 1'b1;
            m_acc     = cyc;
            m_op      = req_op_i;
            m_rs1     = req_rs1_i;
            m_rs2     = req_rs2_i;
            m_tag     = req_tag_i;
            m_to      = TO_EN && (cur_lat > TO - 2);
            m_rsp_rel = m_to ? longint'(TO) + 1 : 3 + longint'(cur_lat);
            ref_div(m_rs1, m_rs2, m_op[0], mq, mr);
            if (m_to) begin
                m_data = '1;
                m_err  = 2'b10;
            end else begin
                m_data = m_op[1] ? mr : mq;
                m_err  = (m_rs2 == '0) ? 2'b01 : (cur_err != '0) ? 2'b11 : 2'b00;
            end
        end
        m_rsp_now = m_busy && (longint'(cyc) - longint'(m_acc)) >= m_rsp_rel;
    end

    // Per-cycle compare plus observations of the DUT for the literal checks.
    longint       rel;
    bit           e_load, e_issue, e_abort, e_rsp;
    int           obs_acc = 0, obs_rise = -1, obs_hs = 0;
    int unsigned  obs_rspcnt = 0, obs_rstcnt = 0;
    logic [W-1:0] obs_data = '0;
    logic [3:0]   obs_tag = '0;
    logic [1:0]   obs_err = '0;

    always @(negedge clk) begin
        rel     = longint'(cyc) - longint'(m_acc);
        e_load  = m_busy && rel == 0;
        e_issue = rst_i && m_busy && rel == 1;
        e_abort = m_busy && m_to && rel == longint'(TO);
        e_rsp   = rst_i && m_busy && rel >= m_rsp_rel;
        check("req_ready", req_ready_o, rst_i && !m_busy);
        check("div_valid", div_valid_o, e_issue);
        check("div_rst", div_rst_o, !rst_i || e_load || e_abort);
        check("rsp_valid", rsp_valid_o, e_rsp);
        if (rst_i && m_busy) begin
            check("div_n", div_n_o, m_rs1);
            check("div_d", div_d_o, m_rs2);
            check("div_unsigned", div_unsigned_o, m_op[0]);
            check("div_out_type", div_out_type_o, !m_op[1]);
        end
        if (e_rsp) begin
            check("rsp_data", rsp_data_o, m_data);
            check("rsp_tag", rsp_tag_o, m_tag);
            check("rsp_err", rsp_err_o, m_err);
        end
        if (req_valid_i && req_ready_o) begin
            obs_acc = cyc; obs_rise = -1; obs_rspcnt = 0; obs_rstcnt = 0;
        end
        if (rst_i && div_rst_o) obs_rstcnt++;
        if (rsp_valid_o) begin
            obs_rspcnt++;
            if (obs_rise < 0) obs_rise = cyc;
            if (rsp_ready_i) begin
                obs_hs = cyc; obs_data = rsp_data_o; obs_tag = rsp_tag_o; obs_err = rsp_err_o;
            end
        end
    end

    task automatic junk();
        req_op_i = 2'($urandom); req_rs1_i = $urandom; req_rs2_i = $urandom; req_tag_i = 4'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] tag, input int unsigned lat, input logic [1:0] err);
        int unsigned k;
        cur_lat = lat; cur_err = err;
        req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_tag_i = tag; req_valid_i = 1'b1;
        k = 0;
        do begin step(); k++; end while (!m_busy && k < 10);
        req_valid_i = 1'b0;
        junk();
    endtask

    task automatic finish_op(input int unsigned hold);
        int unsigned seen, k;
        seen = 0; k = 0;
        rsp_ready_i = (hold == 0);
        while (m_busy && k < 300) begin
            step();
            k++;
            if (m_rsp_now) begin
                seen++;
                if (seen > hold) rsp_ready_i = 1'b1;
            end
        end
        check("rsp_done", m_busy, 1'b0);
        rsp_ready_i = $urandom_range(0, 1);
    endtask

    task automatic reset_pulse();
        rst_i = 1'b0;
        #1;
        check("rst_div_rst", div_rst_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_req_ready", req_ready_o, 1'b0);
        step();
        rst_i = 1'b1;
        #1;
        check("rst_release_ready", req_ready_o, 1'b1);
    endtask

    initial begin
        logic [1:0]   op, e;
        logic [W-1:0] a, b;
        int unsigned  lat;
        junk();
        repeat (3) step();
        rst_i = 1'b1;
        step();

        // DIVU 100/7, divider answers 2 edges after start.
        send(2'b01, 32'd100, 32'd7, 4'hA, 2, 2'b00);
        finish_op(0);
        check("divu_data", obs_data, 32'd14);
        check("divu_err", obs_err, 2'b00);
        check("divu_tag", obs_tag, 4'hA);
        check("divu_latency", 64'(obs_rise - obs_acc), 64'd6);

        // REM -7 % 2 = -1; signed/remainder mode visible during WAIT.
        send(2'b10, 32'hFFFF_FFF9, 32'd2, 4'h3, 2, 2'b00);
        step();
        step();
        check("rem_unsigned_wait", div_unsigned_o, 1'b0);
        check("rem_out_type_wait", div_out_type_o, 1'b0);
        finish_op(0);
        check("rem_data", obs_data, 32'hFFFF_FFFF);
        check("rem_err", obs_err, 2'b00);

        // DIV by zero.
        send(2'b00, 32'd123, 32'd0, 4'h5, 1, 2'b00);
        finish_op(0);
        check("div0_data", obs_data, 32'hFFFF_FFFF);
        check("div0_err", obs_err, 2'b01);

        // Minimum latency with an instant divider.
        send(2'b11, 32'd50, 32'd8, 4'h6, 0, 2'b00);
        finish_op(0);
        check("min_latency", 64'(obs_rise - obs_acc), 64'd4);
        check("remu_data", obs_data, 32'd2);

        // Response held 5 cycles, then a back-to-back request.
        send(2'b01, 32'd9, 32'd3, 4'h7, 1, 2'b11);
        finish_op(5);
        check("hold_rsp_cycles", obs_rspcnt, 6);
        check("hold_err", obs_err, 2'b11);
        send(2'b01, 32'd81, 32'd9, 4'h8, 1, 2'b00);
        check("b2b_accept", 64'(obs_acc - obs_hs), 64'd1);
        finish_op(0);
        check("b2b_data", obs_data, 32'd9);

        // Divider that never answers.
        send(2'b00, 32'd77, 32'd5, 4'h9, NEVER, 2'b00);
`ifdef DIV_ISSUE_TIMEOUT_EN
        finish_op(0);
        check("to_err", obs_err, 2'b10);
        check("to_data", obs_data, 32'hFFFF_FFFF);
        check("to_rst_pulses", obs_rstcnt, 2);
        check("to_latency", 64'(obs_rise - obs_acc), 64'd10);
`else
        repeat (100) step();
        check("stuck_rsp_count", obs_rspcnt, 0);
        check("stuck_req_ready", req_ready_o, 1'b0);
        reset_pulse();
`endif

        // Reset while waiting on the divider drops the op.
        send(2'b01, 32'd40, 32'd4, 4'hB, NEVER, 2'b00);
        step();
        step();
        reset_pulse();
        check("reset_no_rsp", obs_rspcnt, 0);

        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = {1'b1, {(W-1){1'b0}}};
            lat = $urandom_range(0, 4);
`ifdef DIV_ISSUE_TIMEOUT_EN
            if ($urandom_range(0, 4) == 0) lat = $urandom_range(TO - 3, TO);
`endif
            e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            repeat ($urandom_range(0, 2)) step();
            send(op, a, b, 4'($urandom), lat, e);
            finish_op($urandom_range(0, 3));
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
